// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter feeding a shared 4:1 mux onto one registered valid/ready channel.
// Define MUX4_RR_ARBITER_STATS_EN to add per-requester handshake counters on grant_cnt_o.
module mux4_rr_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [3:0]        req_i,
  input  logic [DATA_W-1:0] din_a_i,
  input  logic [DATA_W-1:0] din_b_i,
  input  logic [DATA_W-1:0] din_c_i,
  input  logic [DATA_W-1:0] din_d_i,
  input  logic              dout_ready_i,
  output logic [1:0]        sel_o,
  output logic [DATA_W-1:0] dout_o,
  output logic              dout_valid_o,
  output logic [3:0]        ack_o
`ifdef MUX4_RR_ARBITER_STATS_EN
  ,
  output logic [63:0]       grant_cnt_o
`endif
);

  typedef enum logic {ARB, HOLD} state_e;

  localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

  state_e            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        last_q, last_d;
  logic [3:0]        burst_q, burst_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;

  logic [1:0]        winner;
  logic [1:0]        grant;
  logic [DATA_W-1:0] grant_din;
  logic              handshake;

  assign handshake = valid_q & dout_ready_i;

  // Descending loop so the nearest requester after last_q overwrites farther ones.
  always_comb begin
    logic [1:0] idx;
    winner = last_q;
    for (int k = 4; k >= 1; k--) begin
      idx = last_q + 2'(k);
      if (req_i[idx]) winner = idx;
    end
  end

  always_comb begin
    grant_din = din_a_i;
    case (grant)
      2'd0:    grant_din = din_a_i;
      2'd1:    grant_din = din_b_i;
      2'd2:    grant_din = din_c_i;
      default: grant_din = din_d_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    burst_d = burst_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    grant   = winner;
    case (state_q)
      ARB: begin
        if (req_i != 4'b0000) begin
          if ((burst_q < MaxBurst) && req_i[sel_q]) begin
            grant   = sel_q;
            burst_d = burst_q + 4'd1;
          end else begin
            grant   = winner;
            burst_d = 4'd1;
          end
          sel_d   = grant;
          last_d  = grant;
          dout_d  = grant_din;
          valid_d = 1'b1;
          state_d = HOLD;
        end else begin
          valid_d = 1'b0;
        end
      end
      default: begin
        if (handshake) begin
          valid_d = 1'b0;
          state_d = ARB;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ARB;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
      burst_q <= 4'd0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign sel_o        = sel_q;
  assign dout_o       = dout_q;
  assign dout_valid_o = valid_q;
  assign ack_o        = handshake ? (4'b0001 << sel_q) : 4'b0000;

`ifdef MUX4_RR_ARBITER_STATS_EN
  logic [3:0][15:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (handshake) begin
      cnt_q[sel_q] <= cnt_q[sel_q] + 16'd1;
    end
  end

  assign grant_cnt_o = cnt_q;
`endif

endmodule
